data_mem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 52 +++++
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder:
// RV32I size codes, FSM encodings and counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data port: store enables/shift,
// load shift plus sign/zero extension, alignment check.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    byte_en    = '0;
    misalign   = 1'b0;
    rdata_ext  = '0;
    wdata_lane = wdata << {addr_lo, 3'b000};
    shifted    = raw_rdata >> {addr_lo, 3'b000};
    unique case (funct3)
      F3_B: begin
        byte_en   = 4'b0001 << addr_lo;
        rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        rdata_ext = {24'd0, shifted[7:0]};
      end
      F3_H: begin
        misalign  = addr_lo[0];
        byte_en   = 4'b0011 << addr_lo;
        rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_HU: begin
        misalign  = addr_lo[0];
        byte_en   = 4'b0011 << addr_lo;
        rdata_ext = {16'd0, shifted[15:0]};
      end
      F3_W: begin
        misalign  = |addr_lo;
        byte_en   = 4'b1111;
        rdata_ext = raw_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory slave with programmable wait states,
// internal RAM array and access fault reporting.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN =
    33'(DEPTH_WORDS) * 33'd4;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WAIT_CYCLES - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       f3_q, f3_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic        idle;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_f3;
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        oor;
  logic        bad_size;
  logic        err;
  logic        go;
  logic        commit;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;
  logic        misalign;
  logic        unused_off;

  // With zero wait states the access happens on the accept
  // edge, so the live request must feed the datapath.
  assign idle      = (state_q == S_IDLE);
  assign acc_we    = idle ? req_we     : we_q;
  assign acc_addr  = idle ? req_addr   : addr_q;
  assign acc_wdata = idle ? req_wdata  : wdata_q;
  assign acc_f3    = idle ? req_funct3 : f3_q;

  assign off = acc_addr - BASE_ADDR;
  assign idx = off[AW+1:2];
  assign oor = (acc_addr < BASE_ADDR) ||
               ({1'b0, off} >= SPAN);
  assign unused_off = ^{off[31:AW+2], off[1:0]};

  always_comb begin
    bad_size = 1'b0;
    if (acc_we)
      bad_size = !(acc_f3 inside {F3_B, F3_H, F3_W});
    else
      bad_size = acc_f3 inside {3'd3, 3'd6, 3'd7};
  end

  assign err = misalign | oor | bad_size;

  dmem_lane_align u_align (
    .addr_lo    (acc_addr[1:0]),
    .funct3     (acc_f3),
    .wdata      (acc_wdata),
    .raw_rdata  (mem[idx]),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    go          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          cnt_d   = '0;
          if (WAIT_CYCLES == 0) go = 1'b1;
          else state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST) go = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (go) begin
      state_d     = S_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = err;
      rsp_rdata_d = (err || acc_we) ? '0 : rdata_ext;
    end
  end

  assign commit = go && acc_we && !err && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  assign req_ready = idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: 2-wait-state instance for data/fault paths,
// 0-wait-state instance for back-to-back timing.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_we, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid1, req_we1, req_ready1;
  logic [31:0] req_addr1, req_wdata1;
  logic [2:0]  req_funct31;
  logic        rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;

  data_mem_responder #(
    .DEPTH_WORDS(1024), .WAIT_CYCLES(2),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  data_mem_responder #(
    .DEPTH_WORDS(1024), .WAIT_CYCLES(0),
    .BASE_ADDR(32'h0)
  ) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .req_funct3(req_funct31),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rdata", rsp_rdata, e.rdata);
        check("err", {31'd0, rsp_err}, {31'd0, e.err});
        check("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(n), 32'd0);
  endtask

  task automatic do_req(input logic we,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [2:0] f3,
                        input logic [31:0] er,
                        input logic ee);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    wait_ready();
    sb.push_back('{er, ee, cyc + 3});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0)
      check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    req_valid1 = 1'b0; req_we1 = 1'b0;
    req_addr1 = '0; req_wdata1 = '0; req_funct31 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    repeat (3) @(negedge clk);
    check("idle_valid", {31'd0, rsp_valid}, 32'd0);

    do_req(1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 0);
    do_req(0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 0);
    do_req(0, 32'h13, 32'h0, 3'd0, 32'hFFFFFFDE, 0);
    do_req(0, 32'h13, 32'h0, 3'd4, 32'h000000DE, 0);
    do_req(0, 32'h12, 32'h0, 3'd1, 32'hFFFFDEAD, 0);
    do_req(0, 32'h10, 32'h0, 3'd5, 32'h0000BEEF, 0);
    do_req(1, 32'h11, 32'h000000AA, 3'd0, 32'h0, 0);
    do_req(0, 32'h10, 32'h0, 3'd2, 32'hDEADAAEF, 0);
    do_req(1, 32'h12, 32'h00001234, 3'd1, 32'h0, 0);
    do_req(0, 32'h10, 32'h0, 3'd2, 32'h1234AAEF, 0);
    do_req(0, 32'h11, 32'h0, 3'd2, 32'h0, 1);
    do_req(1, 32'h13, 32'hFFFF, 3'd1, 32'h0, 1);
    do_req(0, 32'h1000, 32'h0, 3'd2, 32'h0, 1);
    do_req(0, 32'h10, 32'h0, 3'd3, 32'h0, 1);
    do_req(1, 32'h10, 32'h0, 3'd4, 32'h0, 1);
    do_req(0, 32'h10, 32'h0, 3'd2, 32'h1234AAEF, 0);
    do_req(0, 32'h0FFC, 32'h0, 3'd7, 32'h0, 1);
    do_req(1, 32'h20, 32'h11112222, 3'd2, 32'h0, 0);
    drain();

    // Reset lands in the first wait cycle of a store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = 32'h20; req_wdata = 32'h55555555;
    req_funct3 = 3'd2;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("wrst_ready", {31'd0, req_ready}, 32'd1);
    check("wrst_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (4) @(negedge clk);
    do_req(0, 32'h20, 32'h0, 3'd2, 32'h11112222, 0);
    drain();

    // Zero wait states, request held high back to back.
    @(negedge clk);
    req_valid1 = 1'b1; req_we1 = 1'b1;
    req_addr1 = 32'h40; req_wdata1 = 32'hCAFEF00D;
    req_funct31 = 3'd2;
    check("z_rdy0", {31'd0, req_ready1}, 32'd1);
    check("z_val0", {31'd0, rsp_valid1}, 32'd0);
    @(negedge clk);
    check("z_rdy1", {31'd0, req_ready1}, 32'd0);
    check("z_val1", {31'd0, rsp_valid1}, 32'd1);
    check("z_err1", {31'd0, rsp_err1}, 32'd0);
    req_we1 = 1'b0; req_funct31 = 3'd2;
    @(negedge clk);
    check("z_rdy2", {31'd0, req_ready1}, 32'd1);
    check("z_val2", {31'd0, rsp_valid1}, 32'd0);
    @(negedge clk);
    check("z_val3", {31'd0, rsp_valid1}, 32'd1);
    check("z_lw", rsp_rdata1, 32'hCAFEF00D);
    req_addr1 = 32'h42; req_funct31 = 3'd1;
    @(negedge clk);
    check("z_rdy4", {31'd0, req_ready1}, 32'd1);
    @(negedge clk);
    req_valid1 = 1'b0;
    check("z_val5", {31'd0, rsp_valid1}, 32'd1);
    check("z_lh", rsp_rdata1, 32'hFFFFCAFE);
    @(negedge clk);
    check("z_val6", {31'd0, rsp_valid1}, 32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
